// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo push arbiter.
// Holds the FSM state encoding and the width-derivation function.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Smallest r with 2**r >= value; used to size index and counter fields.
  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ (which need not be a power of two).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int RW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [RW-1:0]      rr_ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] win,
  output logic [RW-1:0]      win_idx
);

  // cand_idx[k] is the requester examined at priority rank k.
  logic [RW-1:0] cand_idx [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [RW:0] sum;
      assign sum = {1'b0, rr_ptr} + (RW+1)'(gi);
      assign cand_idx[gi] = (sum >= (RW+1)'(NUM_REQ)) ? RW'(sum - (RW+1)'(NUM_REQ))
                                                       : sum[RW-1:0];
    end
  endgenerate

  // Scan from lowest priority upward so the highest-priority hit lands last.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        any     = 1'b1;
        win_idx = cand_idx[k];
      end
    end
    win = '0;
    if (any) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin burst arbiter sharing the fifo_cntl push port between producers.
// Grants are combinational from req/full_ff/state; no push is issued while full.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  localparam int RW        = ceil_log2(NUM_REQ),
  localparam int CW        = ceil_log2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               full_ff,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RW-1:0]      gnt_idx,
  output logic               push,
  output logic               busy,
  output logic [CW-1:0]      burst_cnt
);

  arb_state_e         state_reg, state_next;
  logic [RW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [RW-1:0]      owner_reg, owner_next;
  logic [CW-1:0]      burst_cnt_reg, burst_cnt_next;
  logic [RW-1:0]      gnt_idx_reg;
  logic [NUM_REQ-1:0] gnt_c;
  logic [RW-1:0]      sel_idx;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [RW-1:0]      pick_idx;

  function automatic logic [RW-1:0] wrap_inc(input logic [RW-1:0] idx);
    return (idx == RW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .RW      (RW)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .any     (pick_any),
    .win     (pick_onehot),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    gnt_c          = '0;
    sel_idx        = owner_reg;
    case (state_reg)
      IDLE: begin
        if (!full_ff && pick_any) begin
          gnt_c          = pick_onehot;
          sel_idx        = pick_idx;
          owner_next     = pick_idx;
          burst_cnt_next = CW'(1);
          if (MAX_BURST == 1) rr_ptr_next = wrap_inc(pick_idx);
          else                state_next  = BURST;
        end
      end
      BURST: begin
        // A dropped request costs one bubble; a full fifo only stalls.
        if (!req[owner_reg]) begin
          state_next  = IDLE;
          rr_ptr_next = wrap_inc(owner_reg);
        end else if (!full_ff) begin
          gnt_c[owner_reg] = 1'b1;
          burst_cnt_next   = burst_cnt_reg + 1'b1;
          if (burst_cnt_next == CW'(MAX_BURST)) begin
            state_next  = IDLE;
            rr_ptr_next = wrap_inc(owner_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset drops an in-flight grant immediately, not at the next edge.
  assign gnt       = rst_n ? gnt_c : '0;
  assign push      = |gnt;
  assign gnt_idx   = push ? sel_idx : gnt_idx_reg;
  assign busy      = (state_reg == BURST);
  assign burst_cnt = burst_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      burst_cnt_reg <= '0;
      gnt_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      gnt_idx_reg   <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: directed scenarios plus random traffic
// on three configurations against a queue-free round-robin reference model.
module tb_fifo_push_arb;

  localparam int ND = 3;
  localparam int N_P  [ND] = '{4, 4, 5};
  localparam int MB_P [ND] = '{4, 1, 3};

  typedef struct {
    int owner;
    int beats;
    int ptr;
    bit hold;
    int last_idx;
  } m_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] req_v  [ND];
  logic        full_v [ND];

  logic [3:0] gnt_a, gnt_b;
  logic [4:0] gnt_c;
  logic [1:0] idx_a, idx_b;
  logic [2:0] idx_c;
  logic       push_a, push_b, push_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
  logic [1:0] cnt_c;

  logic [15:0] gnt_v  [ND];
  int          idx_v  [ND];
  logic        push_v [ND];
  logic        busy_v [ND];
  int          cnt_v  [ND];

  assign gnt_v[0]  = 16'(gnt_a);
  assign gnt_v[1]  = 16'(gnt_b);
  assign gnt_v[2]  = 16'(gnt_c);
  assign idx_v[0]  = int'(idx_a);
  assign idx_v[1]  = int'(idx_b);
  assign idx_v[2]  = int'(idx_c);
  assign push_v[0] = push_a;
  assign push_v[1] = push_b;
  assign push_v[2] = push_c;
  assign busy_v[0] = busy_a;
  assign busy_v[1] = busy_b;
  assign busy_v[2] = busy_c;
  assign cnt_v[0]  = int'(cnt_a);
  assign cnt_v[1]  = int'(cnt_b);
  assign cnt_v[2]  = int'(cnt_c);

  fifo_push_arb #(.NUM_REQ(4), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_v[0][3:0]), .full_ff(full_v[0]),
    .gnt(gnt_a), .gnt_idx(idx_a), .push(push_a), .busy(busy_a), .burst_cnt(cnt_a)
  );
  fifo_push_arb #(.NUM_REQ(4), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_v[1][3:0]), .full_ff(full_v[1]),
    .gnt(gnt_b), .gnt_idx(idx_b), .push(push_b), .busy(busy_b), .burst_cnt(cnt_b)
  );
  fifo_push_arb #(.NUM_REQ(5), .MAX_BURST(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_v[2][4:0]), .full_ff(full_v[2]),
    .gnt(gnt_c), .gnt_idx(idx_c), .push(push_c), .busy(busy_c), .burst_cnt(cnt_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  m_t m [ND];
  localparam m_t RST_M = '{owner: 0, beats: 0, ptr: 0, hold: 1'b0, last_idx: 0};

  // Reference: which requester is served this cycle (-1 for none).
  function automatic int ref_pick(m_t s, logic [15:0] rq, logic full, int n);
    if (s.hold) return (rq[s.owner] && !full) ? s.owner : -1;
    if (full) return -1;
    for (int k = 0; k < n; k++) begin
      int i = (s.ptr + k) % n;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  function automatic m_t ref_next(m_t s, logic [15:0] rq, logic full, int n, int mb);
    m_t r;
    int w;
    r = s;
    w = ref_pick(s, rq, full, n);
    if (w >= 0) r.last_idx = w;
    if (s.hold) begin
      if (!rq[s.owner]) begin
        r.hold = 1'b0;
        r.ptr  = (s.owner + 1) % n;
      end else if (!full) begin
        r.beats = s.beats + 1;
        if (r.beats == mb) begin
          r.hold = 1'b0;
          r.ptr  = (s.owner + 1) % n;
        end
      end
    end else if (w >= 0) begin
      r.owner = w;
      r.beats = 1;
      if (mb == 1) r.ptr = (w + 1) % n;
      else         r.hold = 1'b1;
    end
    return r;
  endfunction

  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < ND; d++)
      m[d] = rst_n ? ref_next(m[d], req_v[d], full_v[d], N_P[d], MB_P[d]) : RST_M;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_v[d]  = '0;
      full_v[d] = 1'b0;
      m[d]      = RST_M;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      req_v[d]  = 16'h001F;
      full_v[d] = 1'b0;
      m[d]      = RST_M;
    end
    #2;
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (gnt_v[d] !== 16'h0 || push_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
          idx_v[d] != 0 || cnt_v[d] != 0) begin
        n_bad++;
        $display("FAIL reset_state d=%0d got gnt=%h push=%b busy=%b idx=%0d cnt=%0d want all 0",
                 d, gnt_v[d], push_v[d], busy_v[d], idx_v[d], cnt_v[d]);
      end
    end
    for (int d = 0; d < ND; d++) req_v[d] = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (gnt_v[d] !== 16'h0 || push_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || idx_v[d] != 0) begin
          n_bad++;
          $display("FAIL idle_noreq d=%0d c=%0d got gnt=%h push=%b busy=%b idx=%0d want 0",
                   d, c, gnt_v[d], push_v[d], busy_v[d], idx_v[d]);
        end
      end
      $display("reset/idle cycle %0d: gnt_a=%b push_a=%b", c, gnt_a, push_a);
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic       exp_busy;
    int         exp_cnt;
    do_reset();
    req_v[0] = 16'h000F;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_gnt  = 4'b0001 << ((c / 4) % 4);
      exp_busy = (c % 4) != 0;
      exp_cnt  = (c == 0) ? 0 : ((c - 1) % 4) + 1;
      n_cmp++;
      if (gnt_a !== exp_gnt || push_a !== 1'b1 || busy_a !== exp_busy || cnt_v[0] != exp_cnt) begin
        n_bad++;
        $display("FAIL rr_burst c=%0d got gnt=%b push=%b busy=%b cnt=%0d want gnt=%b push=1 busy=%b cnt=%0d",
                 c, gnt_a, push_a, busy_a, cnt_v[0], exp_gnt, exp_busy, exp_cnt);
      end
      $display("rr cycle %0d: gnt=%b idx=%0d cnt=%0d", c, gnt_a, idx_a, cnt_a);
      advance();
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_gnt;
    do_reset();
    req_v[0] = 16'h000F;
    for (int c = 0; c < 8; c++) begin
      full_v[0] = (c >= 2 && c <= 4);
      @(negedge clk);
      exp_gnt = (c == 7) ? 4'b0010 : (full_v[0] ? 4'b0000 : 4'b0001);
      n_cmp++;
      if (gnt_a !== exp_gnt || push_a !== (exp_gnt != 4'b0000)) begin
        n_bad++;
        $display("FAIL stall_gnt c=%0d got gnt=%b push=%b want gnt=%b", c, gnt_a, push_a, exp_gnt);
      end
      if (full_v[0] || c == 7) begin
        n_cmp++;
        if (cnt_v[0] != (c == 7 ? 4 : 2)) begin
          n_bad++;
          $display("FAIL stall_cnt c=%0d got %0d want %0d", c, cnt_v[0], (c == 7 ? 4 : 2));
        end
      end
      $display("stall cycle %0d: full=%b gnt=%b cnt=%0d", c, full_v[0], gnt_a, cnt_a);
      advance();
    end
  endtask

  task automatic test_drop();
    do_reset();
    req_v[0] = 16'h0005;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0001) begin
      n_bad++;
      $display("FAIL drop_first got gnt=%b want 0001", gnt_a);
    end
    advance();
    req_v[0] = 16'h0004;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b1 || idx_a !== 2'd0) begin
      n_bad++;
      $display("FAIL drop_bubble got gnt=%b busy=%b idx=%0d want gnt=0000 busy=1 idx=0", gnt_a, busy_a, idx_a);
    end
    advance();
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0100 || idx_a !== 2'd2) begin
      n_bad++;
      $display("FAIL drop_next got gnt=%b idx=%0d want gnt=0100 idx=2", gnt_a, idx_a);
    end
    $display("drop: next grant gnt=%b idx=%0d", gnt_a, idx_a);
    advance();
  endtask

  task automatic test_burst1();
    do_reset();
    req_v[1] = 16'h0008;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt_b !== 4'b1000 || idx_b !== 2'd3 || busy_b !== 1'b0 || push_b !== 1'b1) begin
        n_bad++;
        $display("FAIL burst1_single c=%0d got gnt=%b idx=%0d busy=%b push=%b want 1000/3/0/1",
                 c, gnt_b, idx_b, busy_b, push_b);
      end
      $display("burst1 cycle %0d: gnt=%b idx=%0d", c, gnt_b, idx_b);
      advance();
    end
    req_v[1] = 16'h0009;
    @(negedge clk);
    n_cmp++;
    if (gnt_b !== 4'b0001) begin
      n_bad++;
      $display("FAIL burst1_wrap got gnt=%b want 0001", gnt_b);
    end
    advance();
    @(negedge clk);
    n_cmp++;
    if (gnt_b !== 4'b1000 || idx_b !== 2'd3) begin
      n_bad++;
      $display("FAIL burst1_alt got gnt=%b idx=%0d want 1000 idx=3", gnt_b, idx_b);
    end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_v[0] = 16'h0004;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt_a !== 4'b0100) begin
        n_bad++;
        $display("FAIL midrst_own c=%0d got gnt=%b want 0100", c, gnt_a);
      end
      advance();
    end
    req_v[0] = 16'h0006;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0100 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_hold got gnt=%b busy=%b want 0100 busy=1", gnt_a, busy_a);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt_a !== 4'b0000 || push_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_drop got gnt=%b push=%b busy=%b want 0", gnt_a, push_a, busy_a);
    end
    for (int d = 0; d < ND; d++) m[d] = RST_M;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gnt_a !== 4'b0010 || idx_a !== 2'd1) begin
      n_bad++;
      $display("FAIL midrst_after got gnt=%b idx=%0d want 0010 idx=1", gnt_a, idx_a);
    end
    $display("reset mid-burst: first grant gnt=%b idx=%0d", gnt_a, idx_a);
    advance();
  endtask

  task automatic test_random();
    int          wait_c [ND][16];
    int          w;
    logic [15:0] exp_gnt;
    int          exp_idx;
    do_reset();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 16; i++) wait_c[d][i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < ND; d++) begin
        for (int i = 0; i < N_P[d]; i++)
          if ($urandom_range(5) == 0) req_v[d][i] = ~req_v[d][i];
        full_v[d] = ($urandom_range(3) == 0);
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        w       = ref_pick(m[d], req_v[d], full_v[d], N_P[d]);
        exp_gnt = (w >= 0) ? (16'd1 << w) : 16'd0;
        exp_idx = (w >= 0) ? w : m[d].last_idx;
        n_cmp++;
        if (gnt_v[d] !== exp_gnt || push_v[d] !== (w >= 0) || idx_v[d] != exp_idx ||
            busy_v[d] !== m[d].hold || cnt_v[d] != m[d].beats) begin
          n_bad++;
          $display("FAIL rand_model d=%0d c=%0d got gnt=%h push=%b idx=%0d busy=%b cnt=%0d want gnt=%h push=%b idx=%0d busy=%b cnt=%0d",
                   d, c, gnt_v[d], push_v[d], idx_v[d], busy_v[d], cnt_v[d],
                   exp_gnt, (w >= 0), exp_idx, m[d].hold, m[d].beats);
        end
        n_cmp++;
        if (!$onehot0(gnt_v[d]) || (push_v[d] && full_v[d]) ||
            ((gnt_v[d] & ~req_v[d]) != 16'h0) || cnt_v[d] > MB_P[d]) begin
          n_bad++;
          $display("FAIL rand_invariant d=%0d c=%0d got gnt=%h req=%h full=%b push=%b cnt=%0d",
                   d, c, gnt_v[d], req_v[d], full_v[d], push_v[d], cnt_v[d]);
        end
        for (int i = 0; i < N_P[d]; i++) begin
          if (req_v[d][i] && !gnt_v[d][i]) begin
            if (push_v[d]) wait_c[d][i]++;
          end else begin
            wait_c[d][i] = 0;
          end
          n_cmp++;
          if (wait_c[d][i] > N_P[d] * MB_P[d]) begin
            n_bad++;
            $display("FAIL rand_starve d=%0d req=%0d got %0d beats waited want <= %0d",
                     d, i, wait_c[d][i], N_P[d] * MB_P[d]);
          end
        end
      end
      advance();
    end
    $display("random: 3000 cycles on %0d configurations", ND);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_drop();
    test_burst1();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_push_arb.md
Name: fifo_push_arb

Overview:
- Round-robin, burst-capable arbiter that shares the single push port of a fifo_cntl instance between NUM_REQ producers.
- Sits in front of fifo_cntl. Drives its push input, watches full_ff, and supplies the one-hot grant and encoded index the write-data mux uses to select the winning producer's data for the RAM.
- Guarantees no push is ever issued while full_ff is asserted, so no beats are dropped.

Parameters:
- NUM_REQ, 4, number of producers; legal range 2..16.
- MAX_BURST, 4, maximum consecutive beats one owner may push before it must release; legal range 1..15.
- RW, ceil(log2(NUM_REQ)), derived localparam; width of index signals.
- CW, ceil(log2(MAX_BURST+1)), derived localparam; width of the burst counter.

Ports:
- clk  input  1  single clock, shared with fifo_cntl
- rst_n  input  1  asynchronous reset, active-low
- req  input  NUM_REQ  per-producer request; a beat is offered while req[i] is high
- full_ff  input  1  registered full flag from fifo_cntl
- gnt  output  NUM_REQ  one-hot grant; a beat transfers in a cycle where req[i] and gnt[i] are both high
- gnt_idx  output  RW  binary index of the current grant; data-mux select; holds its last value when gnt==0
- push  output  1  push to fifo_cntl; equals OR-reduction of gnt
- busy  output  1  high while in state BURST
- burst_cnt  output  CW  beats taken by the current owner; debug/visibility only

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, gnt_idx=0, busy=0. gnt and push are combinational and are 0 whenever req==0 or full_ff==1.
- gnt, push and gnt_idx are combinational from req, full_ff and registered state, giving zero-cycle grant latency. All state updates occur on posedge clk.
- IDLE:
  - If full_ff=1 or req==0: no grant; state unchanged.
  - Otherwise the winner is the first asserted req[i] scanning upward from rr_ptr with wrap from NUM_REQ-1 to 0. Grant the winner this cycle.
  - Next state: owner<=winner, burst_cnt<=1.
  - If MAX_BURST==1: stay IDLE and set rr_ptr<=winner+1 mod NUM_REQ.
  - Else: go to BURST; rr_ptr is unchanged.
- BURST:
  - req[owner]=1 and full_ff=0: grant owner and increment burst_cnt. If the incremented value equals MAX_BURST, go to IDLE and set rr_ptr<=owner+1 mod NUM_REQ.
  - req[owner]=1 and full_ff=1: stall. No grant; burst_cnt and state hold. Stall cycles do not count toward MAX_BURST.
  - req[owner]=0: no grant this cycle (one bubble). Go to IDLE and set rr_ptr<=owner+1 mod NUM_REQ. Other requesters wait for the next cycle.
  - Non-owner requests are ignored while in BURST.
- Simultaneous events:
  - full_ff rising mid-burst behaves as a stall.
  - A pop on the same cycle does not re-enable the grant; only full_ff is consulted.
- Wrap: rr_ptr and winner arithmetic are modulo NUM_REQ, which need not be a power of 2.
- Reset mid-burst: state returns to IDLE and rr_ptr=0 immediately; any in-flight grant drops combinationally with reset.
- Invariants, to be asserted in the bench:
  - gnt is one-hot or zero.
  - push implies !full_ff.
  - gnt[i] implies req[i].
  - burst_cnt <= MAX_BURST.
  - Any req[i] held high is granted within NUM_REQ*MAX_BURST beats plus full_ff stall cycles.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding: IDLE=1'b0, BURST=1'b1
  - the ceil-log2 constant function used to derive RW and CW
- Sub-module rr_pick:
  - Purely combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, one-hot winner, binary winner index.
- fifo_push_arb holds the FSM, counter, pointer and output gating.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, push=0, busy=0, gnt_idx=0 on every cycle.
- req=4'b1111 held, full_ff=0, MAX_BURST=4 -> gnt=0001 for 4 cycles, then 0010 for 4, then 0100, then 1000, then 0001 again. push=1 every cycle. burst_cnt counts 1,2,3,4 per owner.
- Owner 0 in BURST after 2 beats; full_ff=1 for 3 cycles -> gnt=0 and burst_cnt stays 2 for those cycles. After full_ff=0, owner 0 gets exactly 2 more beats, then gnt moves to 0010.
- req=4'b0101, owner 0 drops req after 1 beat -> one cycle with gnt=0, then gnt=0100 (index 2 wins from rr_ptr=1).
- req=4'b1000 only, MAX_BURST=1 -> gnt=1000 every cycle. rr_ptr wraps 0->0 and gnt_idx stays 3.
- Assert rst_n=0 mid-burst on owner 2 with req=4'b0110 -> gnt=0 immediately. After release, the first grant goes to index 1 (rr_ptr=0).
